wash_payment_ctrl: RTL and testbench

WASH_PAYMENT_CTRL -- requirements
Module: wash_payment_ctrl

---
 rtl/wash_payment_ctrl_if.sv | 33 +++
 rtl/wash_payment_ctrl.sv | 154 +++++++++++++++
 tb/tb_wash_payment_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_payment_ctrl_if.sv
// Bus bundle between the washer payment controller and the outside world.
// The slave side is the controller itself; the master side drives the
// customer inputs and washer feedback and observes the controller outputs.
interface wash_payment_ctrl_if;
  logic       coin;
  logic       sel_double;
  logic       sel_dry;
  logic       start_btn;
  logic       cancel_btn;
  logic       door_closed;
  logic       done;
  logic       start;
  logic       double_wash;
  logic       dry_wash;
  logic       door_lock;
  logic [3:0] credit;
  logic [3:0] refund;
  logic       refund_valid;
  logic       coin_reject;
  logic       busy;

  modport slave (
    input  coin, sel_double, sel_dry, start_btn, cancel_btn, door_closed, done,
    output start, double_wash, dry_wash, door_lock, credit, refund,
           refund_valid, coin_reject, busy
  );

  modport master (
    output coin, sel_double, sel_dry, start_btn, cancel_btn, door_closed, done,
    input  start, double_wash, dry_wash, door_lock, credit, refund,
           refund_valid, coin_reject, busy
  );
endinterface

// File: rtl/wash_payment_ctrl.sv
// Coin-operated washer payment controller: collects credit, accepts a
// programme when enough credit is present and the door is closed, launches
// the washer, holds the door locked until the washer reports completion,
// and refunds change or cancelled credit. Every output is a register.
module wash_payment_ctrl #(
  parameter int PRICE_BASE   = 4,
  parameter int PRICE_DOUBLE = 2,
  parameter int PRICE_DRY    = 3,
  parameter int CREDIT_MAX   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  wash_payment_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, LAUNCH, RUN} state_t;

  localparam logic [4:0] BASE_P   = 5'(PRICE_BASE);
  localparam logic [4:0] DOUBLE_P = 5'(PRICE_DOUBLE);
  localparam logic [4:0] DRY_P    = 5'(PRICE_DRY);
  localparam logic [4:0] CMAX     = 5'(CREDIT_MAX);

  state_t     state, state_next;

  logic [3:0] credit_q, credit_d;
  logic [3:0] refund_q, refund_d;
  logic       refund_valid_q, refund_valid_d;
  logic       coin_reject_q, coin_reject_d;
  logic       start_q, start_d;
  logic       double_q, double_d;
  logic       dry_q, dry_d;
  logic       lock_q, lock_d;
  logic       busy_q, busy_d;

  logic [4:0] price;
  logic [4:0] credit_ext;
  logic       coin_ok;
  logic       cancel_req;
  logic       accept;

  // Price uses the live selection levels; it only matters in the accept cycle.
  // A coin counts only below the saturation value. Acceptance compares the
  // credit already held, so a coin arriving in the same cycle cannot tip it.
  // Cancel outranks start when both buttons arrive together.
  assign price      = BASE_P + (bus.sel_double ? DOUBLE_P : 5'd0)
                             + (bus.sel_dry    ? DRY_P    : 5'd0);
  assign credit_ext = {1'b0, credit_q};
  assign coin_ok    = bus.coin && (credit_ext < CMAX);
  assign cancel_req = (state == COLLECT) && bus.cancel_btn;
  assign accept     = (state == COLLECT) && !bus.cancel_btn && bus.start_btn &&
                      bus.door_closed && (credit_ext >= price);

  // State register and output registers; reset discards any held credit
  // silently and overrides everything else, including a wash in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      credit_q       <= 4'd0;
      refund_q       <= 4'd0;
      refund_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      start_q        <= 1'b0;
      double_q       <= 1'b0;
      dry_q          <= 1'b0;
      lock_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state          <= state_next;
      credit_q       <= credit_d;
      refund_q       <= refund_d;
      refund_valid_q <= refund_valid_d;
      coin_reject_q  <= coin_reject_d;
      start_q        <= start_d;
      double_q       <= double_d;
      dry_q          <= dry_d;
      lock_q         <= lock_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state logic; door_closed is irrelevant once the wash is launched.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (coin_ok) state_next = COLLECT;
      COLLECT: begin
        if (cancel_req)  state_next = IDLE;
        else if (accept) state_next = LAUNCH;
      end
      LAUNCH:  state_next = RUN;
      RUN:     if (bus.done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, so each output lines up with the
  // state it belongs to (start and busy appear together with LAUNCH).
  always_comb begin
    logic [4:0] refund_calc;
    refund_calc    = 5'd0;
    credit_d       = credit_q;
    refund_d       = 4'd0;
    refund_valid_d = 1'b0;
    start_d        = (state_next == LAUNCH);
    busy_d         = (state_next == LAUNCH) || (state_next == RUN);
    double_d       = double_q;
    dry_d          = dry_q;
    lock_d         = lock_q;
    coin_reject_d  = bus.coin &&
                     (!coin_ok || (state == LAUNCH) || (state == RUN));
    unique case (state)
      IDLE, COLLECT: begin
        if (cancel_req) begin
          refund_calc    = credit_ext + {4'd0, coin_ok};
          refund_d       = refund_calc[3:0];
          refund_valid_d = |refund_calc;
          credit_d       = 4'd0;
        end else if (accept) begin
          refund_calc    = credit_ext - price + {4'd0, coin_ok};
          refund_d       = refund_calc[3:0];
          refund_valid_d = |refund_calc;
          credit_d       = 4'd0;
          double_d       = bus.sel_double;
          dry_d          = bus.sel_dry;
          lock_d         = 1'b1;
        end else if (coin_ok) begin
          credit_d       = credit_q + 4'd1;
        end
      end
      LAUNCH: begin
      end
      RUN: begin
        if (bus.done) begin
          lock_d   = 1'b0;
          double_d = 1'b0;
          dry_d    = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.credit       = credit_q;
  assign bus.refund       = refund_q;
  assign bus.refund_valid = refund_valid_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.start        = start_q;
  assign bus.double_wash  = double_q;
  assign bus.dry_wash     = dry_q;
  assign bus.door_lock    = lock_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_wash_payment_ctrl.sv
// Scoreboard bench for wash_payment_ctrl: directed scenarios push the pulse
// events they expect (refund, start, coin reject) into a queue, and a
// monitor pops and compares whenever the controller emits a pulse. Level
// outputs (credit, door lock, busy, options) are compared directly.
module tb_wash_payment_ctrl;

  localparam logic [1:0] K_REFUND = 2'd0;
  localparam logic [1:0] K_START  = 2'd1;
  localparam logic [1:0] K_REJECT = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] value;
    logic       dbl;
    logic       dry;
  } ev_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  ev_t  exp_q[$];

  wash_payment_ctrl_if bus ();

  wash_payment_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expectEvent(input logic [1:0] kind, input logic [3:0] value,
                             input logic dbl, input logic dry);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    e.dbl   = dbl;
    e.dry   = dry;
    exp_q.push_back(e);
  endtask

  task automatic compareEvent(input ev_t got);
    ev_t want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_pulse: got kind %0d value %0d dbl %0d dry %0d, expected none",
               got.kind, got.value, got.dbl, got.dry);
    end else begin
      want = exp_q.pop_front();
      if (got != want) begin
        errors++;
        $display("[TB] FAIL pulse_event: got kind %0d value %0d dbl %0d dry %0d, expected kind %0d value %0d dbl %0d dry %0d",
                 got.kind, got.value, got.dbl, got.dry,
                 want.kind, want.value, want.dbl, want.dry);
      end
    end
  endtask

  // Monitor: sample pulse outputs mid-cycle and match them against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.refund_valid) compareEvent({K_REFUND, bus.refund, 1'b0, 1'b0});
      if (bus.start)        compareEvent({K_START, 4'd0, bus.double_wash, bus.dry_wash});
      if (bus.coin_reject)  compareEvent({K_REJECT, 4'd0, 1'b0, 1'b0});
    end
  end

  // One-cycle pulse on any combination of coin, start_btn and cancel_btn.
  task automatic applyStimulus(input logic c, input logic s, input logic x);
    bus.coin       = c;
    bus.start_btn  = s;
    bus.cancel_btn = x;
    tick();
    bus.coin       = 1'b0;
    bus.start_btn  = 1'b0;
    bus.cancel_btn = 1'b0;
  endtask

  task automatic insertCoins(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulseDone();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.coin        = 1'b0;
    bus.sel_double  = 1'b0;
    bus.sel_dry     = 1'b0;
    bus.start_btn   = 1'b0;
    bus.cancel_btn  = 1'b0;
    bus.door_closed = 1'b1;
    bus.done        = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset_credit", bus.credit, 0);
    checkOutput("reset_lock", bus.door_lock, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_start", bus.start, 0);

    // Normal programme: 5 coins, price 4, change 1.
    insertCoins(5);
    checkOutput("normal_credit", bus.credit, 5);
    expectEvent(K_REFUND, 4'd1, 1'b0, 1'b0);
    expectEvent(K_START, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("launch_busy", bus.busy, 1);
    checkOutput("launch_lock", bus.door_lock, 1);
    checkOutput("launch_credit", bus.credit, 0);
    tick();
    checkOutput("run_start_low", bus.start, 0);
    checkOutput("run_lock", bus.door_lock, 1);
    tick();
    checkOutput("run_lock_hold", bus.door_lock, 1);
    pulseDone();
    checkOutput("done_lock", bus.door_lock, 0);
    checkOutput("done_busy", bus.busy, 0);

    // Double + dry: price 9, exact credit, no refund.
    bus.sel_double = 1'b1;
    bus.sel_dry    = 1'b1;
    insertCoins(9);
    expectEvent(K_START, 4'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("opt_double", bus.double_wash, 1);
    checkOutput("opt_dry", bus.dry_wash, 1);
    pulseDone();
    checkOutput("opt_double_clr", bus.double_wash, 0);
    checkOutput("opt_dry_clr", bus.dry_wash, 0);

    // Double + dry with 8 coins: start refused.
    insertCoins(8);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("short_credit", bus.credit, 8);
    checkOutput("short_busy", bus.busy, 0);
    pulseDone();
    checkOutput("done_ignored_credit", bus.credit, 8);
    expectEvent(K_REFUND, 4'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("cancel8_credit", bus.credit, 0);
    bus.sel_double = 1'b0;
    bus.sel_dry    = 1'b0;

    // Saturation: 16th coin rejected, then running-coin reject.
    insertCoins(15);
    expectEvent(K_REJECT, 4'd0, 1'b0, 1'b0);
    insertCoins(1);
    checkOutput("sat_credit", bus.credit, 15);
    expectEvent(K_REFUND, 4'd11, 1'b0, 1'b0);
    expectEvent(K_START, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    expectEvent(K_REJECT, 4'd0, 1'b0, 1'b0);
    insertCoins(1);
    checkOutput("run_coin_credit", bus.credit, 0);
    pulseDone();

    // Cancel with a coin in the same cycle.
    insertCoins(3);
    expectEvent(K_REFUND, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("cancel_credit", bus.credit, 0);
    checkOutput("cancel_busy", bus.busy, 0);

    // Cancel and start together: cancel wins.
    insertCoins(4);
    expectEvent(K_REFUND, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("both_busy", bus.busy, 0);
    checkOutput("both_credit", bus.credit, 0);

    // Cancel during RUN is ignored.
    insertCoins(4);
    expectEvent(K_START, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("run_cancel_busy", bus.busy, 1);
    checkOutput("run_cancel_lock", bus.door_lock, 1);
    pulseDone();

    // Door open blocks start; closing it then allows it.
    insertCoins(6);
    bus.door_closed = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("door_open_credit", bus.credit, 6);
    checkOutput("door_open_busy", bus.busy, 0);
    bus.door_closed = 1'b1;
    expectEvent(K_REFUND, 4'd2, 1'b0, 1'b0);
    expectEvent(K_START, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    bus.door_closed = 1'b0;
    tick();
    checkOutput("door_run_lock", bus.door_lock, 1);
    checkOutput("door_run_busy", bus.busy, 1);
    bus.door_closed = 1'b1;
    pulseDone();

    // Reset in RUN: lock and busy drop, no refund.
    insertCoins(4);
    expectEvent(K_START, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_run_lock", bus.door_lock, 0);
    checkOutput("rst_run_busy", bus.busy, 0);

    // Reset with held credit: credit discarded silently, back in IDLE.
    insertCoins(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_credit", bus.credit, 0);
    insertCoins(1);
    checkOutput("rst_idle_coin", bus.credit, 1);
    expectEvent(K_REFUND, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    tick();
    tick();
    checkOutput("queue_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
